// File: rtl/alu_mul_sequencer_if.sv
// Multiply request/response and ALU operand-port bundle for alu_mul_sequencer.
// The sequencer is the slave; the pipeline/ALU side is the master.
interface alu_mul_sequencer_if #(parameter int XLEN = 32);
  logic            start;
  logic [XLEN-1:0] MulOpA;
  logic [XLEN-1:0] MulOpB;
  logic [XLEN-1:0] PipeOpA;
  logic [XLEN-1:0] PipeOpB;
  logic [XLEN-1:0] PipeExtImm;
  logic [2:0]      PipeFunc;
  logic            PipeOpBSrc;
  logic [XLEN-1:0] AluOpA;
  logic [XLEN-1:0] AluOpB;
  logic [XLEN-1:0] AluExtImm;
  logic [2:0]      AluFunc;
  logic            AluOpBSrc;
  logic [XLEN-1:0] AluResult;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] mul_result;

  modport master (
    output start, MulOpA, MulOpB, PipeOpA, PipeOpB, PipeExtImm, PipeFunc, PipeOpBSrc, AluResult,
    input  AluOpA, AluOpB, AluExtImm, AluFunc, AluOpBSrc, busy, stall, done, mul_result
  );

  modport slave (
    input  start, MulOpA, MulOpB, PipeOpA, PipeOpB, PipeExtImm, PipeFunc, PipeOpBSrc, AluResult,
    output AluOpA, AluOpB, AluExtImm, AluFunc, AluOpBSrc, busy, stall, done, mul_result
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-add MUL (low XLEN bits) that borrows the execute-stage ALU adder,
// one ADD per multiplier bit, stalling the pipeline while it owns the ALU.
module alu_mul_sequencer #(
  parameter int XLEN       = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input logic              clk,
  input logic              reset_n,
  alu_mul_sequencer_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [XLEN-1:0] mcand, mplier, acc, acc_nxt, mul_result;
  logic [CW-1:0]   cnt;
  logic            done, last, run, zero_op;

  assign run     = (state == RUN);
  assign acc_nxt = mplier[0] ? bus.AluResult : acc;
  assign last    = (cnt == CW'(XLEN - 1)) || (EARLY_EXIT && ((mplier >> 1) == '0));
  assign zero_op = (bus.MulOpB == '0) || (EARLY_EXIT && (bus.MulOpA == '0));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
      mul_result <= '0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            mcand  <= bus.MulOpA;
            mplier <= bus.MulOpB;
            acc    <= '0;
            cnt    <= '0;
            if (zero_op) begin
              state      <= DONE;
              mul_result <= '0;
              done       <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // Capture the final add directly so the result is valid with done.
          if (last) begin
            state      <= DONE;
            mul_result <= acc_nxt;
            done       <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.stall      = ((state == IDLE) && bus.start) || run;
  assign bus.done       = done;
  assign bus.mul_result = mul_result;

  // ALU belongs to the pipeline except while iterating.
  assign bus.AluOpA    = run ? acc    : bus.PipeOpA;
  assign bus.AluOpB    = run ? mcand  : bus.PipeOpB;
  assign bus.AluExtImm = run ? '0     : bus.PipeExtImm;
  assign bus.AluFunc   = run ? 3'b000 : bus.PipeFunc;
  assign bus.AluOpBSrc = run ? 1'b0   : bus.PipeOpBSrc;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer: one early-exit and one full-length
// instance share stimulus; a behavioural ALU closes the loop.
module tb_alu_mul_sequencer;
  logic clk, reset_n;
  int total = 0;
  int bad   = 0;

  alu_mul_sequencer_if #(.XLEN(32)) m0 ();
  alu_mul_sequencer_if #(.XLEN(32)) m1 ();

  alu_mul_sequencer #(.XLEN(32), .EARLY_EXIT(1'b1)) dut0 (.clk(clk), .reset_n(reset_n), .bus(m0));
  alu_mul_sequencer #(.XLEN(32), .EARLY_EXIT(1'b0)) dut1 (.clk(clk), .reset_n(reset_n), .bus(m1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu(input logic [31:0] a, b, imm, input logic [2:0] f, input logic src);
    logic [31:0] bb;
    bb = src ? imm : b;
    case (f)
      3'b000:  return a + bb;
      3'b001:  return a - bb;
      default: return a & bb;
    endcase
  endfunction

  assign m0.AluResult  = alu(m0.AluOpA, m0.AluOpB, m0.AluExtImm, m0.AluFunc, m0.AluOpBSrc);
  assign m1.AluResult  = alu(m1.AluOpA, m1.AluOpB, m1.AluExtImm, m1.AluFunc, m1.AluOpBSrc);
  assign m1.start      = m0.start;
  assign m1.MulOpA     = m0.MulOpA;
  assign m1.MulOpB     = m0.MulOpB;
  assign m1.PipeOpA    = m0.PipeOpA;
  assign m1.PipeOpB    = m0.PipeOpB;
  assign m1.PipeExtImm = m0.PipeExtImm;
  assign m1.PipeFunc   = m0.PipeFunc;
  assign m1.PipeOpBSrc = m0.PipeOpBSrc;

  // Number of RUN cycles for a given operand pair.
  function automatic int klen(input logic [31:0] a, b, input bit ee);
    if (b == 0 || (ee && a == 0)) return 0;
    if (!ee) return 32;
    for (int i = 31; i >= 0; i--) if (b[i]) return i + 1;
    return 0;
  endfunction

  task automatic do_mul(input string name, input logic [31:0] a, b, input bit hold);
    logic [31:0] exp, r0, r1;
    int k0, k1, lat0, lat1, n0, n1;
    bit sbad;
    exp = a * b; k0 = klen(a, b, 1'b1); k1 = klen(a, b, 1'b0);
    lat0 = 0; lat1 = 0; n0 = 0; n1 = 0; r0 = '0; r1 = '0; sbad = 1'b0;
    @(posedge clk); #1;
    m0.MulOpA = a; m0.MulOpB = b; m0.start = 1'b1;
    @(negedge clk);
    total++;
    if (m0.stall !== 1'b1 || m0.busy !== 1'b0)
      begin bad++; $display("FAIL %s start_cycle: stall=%b busy=%b want 1/0", name, m0.stall, m0.busy); end
    @(posedge clk); #1;
    if (!hold) m0.start = 1'b0;
    m0.MulOpA = ~a; m0.MulOpB = ~b;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (c <= k0 + 1 && m0.stall !== (c <= k0)) sbad = 1'b1;
      if (c <= k1 + 1 && m1.stall !== (c <= k1)) sbad = 1'b1;
      if (m0.done === 1'b1) begin n0++; if (lat0 == 0) begin lat0 = c; r0 = m0.mul_result; end end
      if (m1.done === 1'b1) begin n1++; if (lat1 == 0) begin lat1 = c; r1 = m1.mul_result; end end
      @(posedge clk); #1;
      if (hold && n0 > 0) m0.start = 1'b0;
    end
    total++; if (lat0 != k0 + 1) begin bad++; $display("FAIL %s lat_ee: got %0d want %0d", name, lat0, k0 + 1); end
    total++; if (lat1 != k1 + 1) begin bad++; $display("FAIL %s lat_full: got %0d want %0d", name, lat1, k1 + 1); end
    total++; if (n0 != 1) begin bad++; $display("FAIL %s pulses_ee: got %0d want 1", name, n0); end
    total++; if (n1 != 1) begin bad++; $display("FAIL %s pulses_full: got %0d want 1", name, n1); end
    total++; if (r0 !== exp) begin bad++; $display("FAIL %s result_ee: got %h want %h", name, r0, exp); end
    total++; if (r1 !== exp) begin bad++; $display("FAIL %s result_full: got %h want %h", name, r1, exp); end
    total++; if (sbad) begin bad++; $display("FAIL %s stall_window: got wrong stall want high only during RUN", name); end
    total++; if (m0.mul_result !== exp) begin bad++; $display("FAIL %s result_held: got %h want %h", name, m0.mul_result, exp); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; m0.start = 1'b0; m0.MulOpA = '0; m0.MulOpB = '0;
    m0.PipeOpA = '0; m0.PipeOpB = '0; m0.PipeExtImm = '0; m0.PipeFunc = 3'b000; m0.PipeOpBSrc = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (m0.busy !== 1'b0 || m0.done !== 1'b0 || m0.stall !== 1'b0 || m0.mul_result !== '0)
      begin bad++; $display("FAIL reset_ee: busy=%b done=%b stall=%b res=%h want 0", m0.busy, m0.done, m0.stall, m0.mul_result); end
    total++;
    if (m1.busy !== 1'b0 || m1.done !== 1'b0 || m1.mul_result !== '0)
      begin bad++; $display("FAIL reset_full: busy=%b done=%b res=%h want 0", m1.busy, m1.done, m1.mul_result); end
    reset_n = 1'b1;
  endtask

  task automatic test_arb();
    logic [31:0] ea [3];
    logic [31:0] eb [3];
    ea = '{32'd0, 32'd3, 32'd3};
    eb = '{32'd3, 32'd6, 32'd12};
    @(posedge clk); #1;
    m0.PipeOpA = 32'd7; m0.PipeOpB = 32'd9; m0.PipeFunc = 3'b001; m0.PipeExtImm = 32'd5; m0.PipeOpBSrc = 1'b1;
    @(negedge clk);
    total++;
    if (m0.AluOpA !== 32'd7 || m0.AluOpB !== 32'd9 || m0.AluFunc !== 3'b001)
      begin bad++; $display("FAIL arb_idle: a=%0d b=%0d f=%b want 7/9/001", m0.AluOpA, m0.AluOpB, m0.AluFunc); end
    total++;
    if (m0.AluExtImm !== 32'd5 || m0.AluOpBSrc !== 1'b1)
      begin bad++; $display("FAIL arb_idle_imm: imm=%0d src=%b want 5/1", m0.AluExtImm, m0.AluOpBSrc); end
    @(posedge clk); #1;
    m0.MulOpA = 32'd3; m0.MulOpB = 32'd5; m0.start = 1'b1;
    @(posedge clk); #1;
    m0.start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (m0.AluOpA !== ea[c] || m0.AluOpB !== eb[c] || m0.AluFunc !== 3'b000 || m0.AluOpBSrc !== 1'b0 || m0.AluExtImm !== '0)
        begin bad++; $display("FAIL arb_run%0d: a=%0d b=%0d f=%b src=%b want %0d/%0d/000/0", c, m0.AluOpA, m0.AluOpB, m0.AluFunc, m0.AluOpBSrc, ea[c], eb[c]); end
    end
    @(negedge clk);
    total++;
    if (m0.done !== 1'b1 || m0.mul_result !== 32'd15 || m0.AluOpA !== 32'd7 || m0.AluFunc !== 3'b001)
      begin bad++; $display("FAIL arb_done: done=%b res=%0d a=%0d f=%b want 1/15/7/001", m0.done, m0.mul_result, m0.AluOpA, m0.AluFunc); end
    m0.PipeOpBSrc = 1'b0; m0.PipeExtImm = '0;
    repeat (35) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    m0.MulOpA = 32'h0001_0000; m0.MulOpB = 32'h0001_0000; m0.start = 1'b1;
    @(posedge clk); #1;
    m0.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (m0.busy !== 1'b0 || m0.done !== 1'b0 || m0.mul_result !== '0)
      begin bad++; $display("FAIL reset_mid_ee: busy=%b done=%b res=%h want 0/0/0", m0.busy, m0.done, m0.mul_result); end
    total++;
    if (m1.busy !== 1'b0 || m1.mul_result !== '0)
      begin bad++; $display("FAIL reset_mid_full: busy=%b res=%h want 0/0", m1.busy, m1.mul_result); end
    @(posedge clk); #1 reset_n = 1'b1;
    do_mul("after_reset", 32'd6, 32'd7, 1'b0);
  endtask

  initial begin
    test_reset();
    test_arb();
    do_mul("t1_3x5", 32'd3, 32'd5, 1'b0);
    do_mul("t2_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_mul("t3_b_zero", 32'h0000_1234, 32'd0, 1'b0);
    do_mul("a_zero", 32'd0, 32'h0000_0013, 1'b0);
    test_reset_mid();
    do_mul("t6_hold", 32'h8000_0000, 32'd2, 1'b1);
    do_mul("neg_x_pos", 32'hFFFF_FFFD, 32'd7, 1'b0);
    do_mul("msb_mplier", 32'h0000_0003, 32'h8000_0001, 1'b0);
    do_mul("one_x_one", 32'd1, 32'd1, 1'b0);
    for (int i = 0; i < 6; i++)
      do_mul("random", $urandom, $urandom >> (i * 5), 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
